// File: rtl/ps2_event_ctrl.sv
// PS/2 set-2 scan-code sequencer: folds E0/F0/E1 prefixes into key events and queues them in a FWFT FIFO.
// Event becomes visible one cycle after its final byte; a push into a full FIFO is dropped and flagged.
module ps2_event_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  input  logic                          parity_ok,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          overflow,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            push_q, push_d;
  evt_t            push_evt_q, push_evt_d;
  evt_t            mem_q [FIFO_DEPTH];
  evt_t            mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            parity_err_q, parity_err_d;
  logic            overflow_q, overflow_d;

  logic            pop, full, wr, ovf_set;

  // Prefix sequencer; a completed event is staged in push_q and written to the FIFO next cycle.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    push_d     = 1'b0;
    push_evt_d = push_evt_q;
    if (byte_valid) begin
      tmo_d = '0;
      if (!parity_ok) begin
        state_d = S_IDLE;
        skip_d  = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            case (byte_data)
              8'hE0: state_d = S_EXT;
              8'hF0: state_d = S_BRK;
              8'hE1: begin
                push_d     = 1'b1;
                push_evt_d = '{code: byte_data, ext: 1'b0, brk: 1'b0};
                state_d    = S_PAUSE;
                skip_d     = 3'd7;
              end
              8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC: ;
              default: begin
                push_d     = 1'b1;
                push_evt_d = '{code: byte_data, ext: 1'b0, brk: 1'b0};
              end
            endcase
          end
          S_EXT: begin
            if (byte_data == 8'hF0) begin
              state_d = S_EXT_BRK;
            end else if (byte_data != 8'hE0) begin
              push_d     = 1'b1;
              push_evt_d = '{code: byte_data, ext: 1'b1, brk: 1'b0};
              state_d    = S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            state_d = S_IDLE;
            if (byte_data != 8'hE0 && byte_data != 8'hF0) begin
              push_d     = 1'b1;
              push_evt_d = '{code: byte_data, ext: (state_q == S_EXT_BRK), brk: 1'b1};
            end
          end
          S_PAUSE: begin
            skip_d = skip_q - 3'd1;
            if (skip_q <= 3'd1) begin
              state_d = S_IDLE;
              skip_d  = '0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      // Stale partial sequence: abandon silently.
      state_d = S_IDLE;
      skip_d  = '0;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    pop     = (count_q != '0) && evt_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    wr      = push_q && (!full || pop);
    ovf_set = push_q && full && !pop;

    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = push_evt_q;

    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (!wr && pop) count_d = count_q - CW'(1);

    // A new error in the same cycle as err_clr must survive.
    parity_err_d = (parity_err_q && !err_clr) || (byte_valid && !parity_ok);
    overflow_d   = (overflow_q && !err_clr) || ovf_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      skip_q       <= '0;
      tmo_q        <= '0;
      push_q       <= 1'b0;
      push_evt_q   <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      tmo_q        <= tmo_d;
      push_q       <= push_d;
      push_evt_q   <= push_evt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_code   = mem_q[rd_ptr_q].code;
  assign evt_ext    = mem_q[rd_ptr_q].ext;
  assign evt_break  = mem_q[rd_ptr_q].brk;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE);
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_event_ctrl.sv
// Bench for ps2_event_ctrl: directed scenarios plus random byte streams against a prefix/queue reference model.
module tb_ps2_event_ctrl;

  localparam int D = 8;
  localparam int T = 40;

  logic                clk = 1'b0;
  logic                reset;
  logic                byte_valid, parity_ok, evt_ready, err_clr;
  logic [7:0]          byte_data;
  logic                evt_valid, evt_ext, evt_break, busy, parity_err, overflow;
  logic [7:0]          evt_code;
  logic [$clog2(D):0]  fifo_count;

  ps2_event_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .parity_ok(parity_ok), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .fifo_count(fifo_count), .busy(busy), .parity_err(parity_err),
    .overflow(overflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: pending-prefix flags, pause byte budget, event queue.
  bit [9:0] exp_q[$];
  bit       m_ext, m_brk, m_perr, m_ovf, mp_vld;
  bit [9:0] mp_val;
  int       m_skip, m_since;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return m_ext || m_brk || (m_skip > 0);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_perr = 0; m_ovf = 0; mp_vld = 0; mp_val = '0;
    m_skip = 0; m_since = 0;
  endtask

  task automatic model_byte(input bit [7:0] b, input bit par);
    if (!par) begin
      m_perr = 1; m_ext = 0; m_brk = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (m_ext || m_brk) begin
      if (b == 8'hF0) begin
        if (m_brk) begin m_ext = 0; m_brk = 0; end
        else m_brk = 1;
      end else if (b == 8'hE0) begin
        if (m_brk) begin m_ext = 0; m_brk = 0; end
      end else begin
        mp_vld = 1; mp_val = {b, m_ext, m_brk};
        m_ext = 0; m_brk = 0;
      end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: begin mp_vld = 1; mp_val = {b, 2'b00}; m_skip = 7; end
        8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC: ;
        default: begin mp_vld = 1; mp_val = {b, 2'b00}; end
      endcase
    end
  endtask

  task automatic model_edge();
    bit full_pre, pop;
    full_pre = (exp_q.size() == D);
    pop = (exp_q.size() > 0) && evt_ready;
    if (err_clr) begin m_perr = 0; m_ovf = 0; end
    if (pop) void'(exp_q.pop_front());
    if (mp_vld) begin
      if (full_pre && !pop) m_ovf = 1;
      else exp_q.push_back(mp_val);
    end
    mp_vld = 0;
    if (byte_valid) begin
      m_since = 0;
      model_byte(byte_data, parity_ok);
    end else if (m_busy()) begin
      m_since++;
      if (m_since == T) begin m_ext = 0; m_brk = 0; m_skip = 0; m_since = 0; end
    end
  endtask

  task automatic check_all();
    bit [9:0] h;
    chk("evt_valid", evt_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("evt_code", evt_code, h[9:2]);
      chk("evt_ext", evt_ext, h[1]);
      chk("evt_break", evt_break, h[0]);
    end
    chk("fifo_count", fifo_count, exp_q.size());
    chk("busy", busy, m_busy());
    chk("parity_err", parity_err, m_perr);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit bv, input bit [7:0] b, input bit par, input bit clr);
    byte_valid = bv; byte_data = b; parity_ok = par; err_clr = clr;
    step();
    byte_valid = 0; err_clr = 0;
  endtask

  task automatic send(input bit [7:0] b);
    drive(1'b1, b, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1;
    #1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    bit [7:0] t3 [8];
    byte_valid = 0; byte_data = 0; parity_ok = 1; evt_ready = 0; err_clr = 0;
    reset = 1;
    model_reset();
    #1;
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", evt_code, 0);
    chk("rst_evt_ext", evt_ext, 0);
    chk("rst_evt_break", evt_break, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overflow", overflow, 0);
    apply_reset();

    // T1: make then break of 1C
    evt_ready = 1;
    send(8'h1C);
    chk("t1_not_yet", evt_valid, 0);
    idle(1);
    chk("t1_make_valid", evt_valid, 1);
    chk("t1_make_code", evt_code, 8'h1C);
    chk("t1_make_brk", evt_break, 0);
    send(8'hF0); send(8'h1C); idle(1);
    chk("t1_brk_code", evt_code, 8'h1C);
    chk("t1_brk_brk", evt_break, 1);
    idle(2);

    // T2: extended make and break
    send(8'hE0);
    chk("t2_busy", busy, 1);
    send(8'h75); idle(1);
    chk("t2_make_ext", {evt_valid, evt_code, evt_ext, evt_break}, {1'b1, 8'h75, 2'b10});
    send(8'hE0); send(8'hF0);
    chk("t2_busy_brk", busy, 1);
    send(8'h75); idle(1);
    chk("t2_brk_ext", {evt_valid, evt_code, evt_ext, evt_break}, {1'b1, 8'h75, 2'b11});
    idle(2);

    // T3: pause sequence yields a single event
    evt_ready = 0;
    t3 = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(t3[i]);
    chk("t3_busy_end", busy, 0);
    idle(1);
    chk("t3_count", fifo_count, 1);
    chk("t3_code", evt_code, 8'hE1);
    evt_ready = 1; idle(2);

    // T4: overflow, ordered drain, clear
    evt_ready = 0;
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    idle(1);
    chk("t4_count", fifo_count, 8);
    chk("t4_ovf", overflow, 1);
    evt_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", evt_code, 8'h10 + 8'(i));
      idle(1);
    end
    chk("t4_empty", fifo_count, 0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t4_ovf_clr", overflow, 0);

    // T5: timeout abandons a pending break prefix
    send(8'hF0);
    idle(T - 1);
    chk("t5_still_busy", busy, 1);
    idle(1);
    chk("t5_timed_out", busy, 0);
    chk("t5_no_evt", fifo_count, 0);
    send(8'h1C); idle(1);
    chk("t5_make", {evt_valid, evt_code, evt_break}, {1'b1, 8'h1C, 1'b0});
    idle(2);

    // T6: parity error aborts; reset drops queued events
    send(8'hE0);
    drive(1'b1, 8'h75, 1'b0, 1'b0);
    chk("t6_perr", parity_err, 1);
    chk("t6_busy", busy, 0);
    idle(1);
    chk("t6_no_evt", evt_valid, 0);
    evt_ready = 0;
    send(8'h21); send(8'h22); send(8'h23); idle(1);
    send(8'hE0);
    chk("t6_queued", fifo_count, 3);
    #2 reset = 1;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;

    // Random byte streams with varying consumer behaviour
    for (int blk = 0; blk < 50; blk++) begin
      int mode = $urandom_range(0, 2);
      for (int c = 0; c < 64; c++) begin
        bit [7:0] b;
        int sel;
        evt_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 15);
        case (sel)
          0, 1: b = 8'hE0;
          2, 3: b = 8'hF0;
          4:    b = 8'hE1;
          5:    b = 8'hAA;
          6:    b = 8'h00;
          default: b = 8'($urandom_range(0, 255));
        endcase
        drive($urandom_range(0, 9) < 4, b, $urandom_range(0, 15) != 0,
              $urandom_range(0, 39) == 0);
      end
    end
    evt_ready = 1;
    idle(T + 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
